apix_upstream_tx: RTL and testbench

- Back-channel serializer on the display/receiver end of the APIX link, driving the direction opposite to the downstream pixel path.
- Queues 8-bit command bytes from local control logic.
- Counts error pulses from the local pixel receiver.
- Sends both as fixed-format serial frames with a bit strobe toward the source-side back-channel deserializer.
- Error reports take priority over queued commands at frame boundaries.

---
 rtl/apix_upstream_tx.sv | 218 +++++++++++++++++++++
 tb/tb_apix_upstream_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apix_upstream_tx.sv
// ---------------------------------------------------------------------------
// apix_upstream_tx
//   Back-channel serializer for the receiver end of an APIX link. Local
//   command bytes are queued in a small FIFO. Pixel-receiver error pulses are
//   counted in a saturating 8-bit counter. Both kinds of payload leave as
//   12-bit serial frames with a mid-bit strobe. At every frame boundary a
//   pending error report is sent before any queued command.
//
//   Frame (first bit first): start 0, type (0 cmd / 1 err), payload[0..7],
//   even parity over type+payload, stop 1. Each bit lasts CLK_DIV cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_data   command byte
//   cmd_valid  cmd_data valid
//   cmd_ready  FIFO not full (combinational from FIFO occupancy)
//   err_in     one-cycle error pulse from the pixel receiver
//   up_data    serial line, idles high (registered)
//   up_clk     one-cycle strobe at bit-cycle index CLK_DIV/2 (registered)
//   busy       high while a frame or its trailing gap is in progress (registered)
// ---------------------------------------------------------------------------
module apix_upstream_tx #(
    parameter int CLK_DIV    = 4,   // even, >= 2
    parameter int FIFO_DEPTH = 4,   // power of two, >= 2
    parameter int GAP_BITS   = 2    // >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       err_in,
    output logic       up_data,
    output logic       up_clk,
    output logic       busy
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W1  = PTR_W + 1;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    // The strobe register is set one cycle early so it is high at index CLK_DIV/2.
    localparam logic [DIV_W-1:0]  DIV_PRE_MID = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(GAP_CYC - 1);
    localparam logic [PTR_W1-1:0] FIFO_FULL   = PTR_W1'(FIFO_DEPTH);

    // Even parity bit: makes the total count of ones (bits + parity) even.
    function automatic logic even_parity(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Frame image, bit 0 is transmitted first.
    function automatic logic [11:0] build_frame(input logic typ, input logic [7:0] payload);
        return {1'b1, even_parity({payload, typ}), payload, typ, 1'b0};
    endfunction

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W1-1:0] r_wr_ptr;
    logic [PTR_W1-1:0] r_rd_ptr;

    // Error counter and transmit state
    logic [7:0]        r_err_cnt;
    logic [1:0]        r_state;
    logic [10:0]       r_shift;      // bits still to send after the current one
    logic [3:0]        r_bit;        // index of bit currently on the line
    logic [DIV_W-1:0]  r_cyc;        // cycle within the current bit
    logic [GAP_W-1:0]  r_gap;
    logic              r_up_data;
    logic              r_up_clk;
    logic              r_busy;

    logic [PTR_W1-1:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_load_err;
    logic              w_load_cmd;
    logic [11:0]       w_frame;

    // FIFO status, push/load decisions and the frame image for a load
    always_comb begin
        w_count    = r_wr_ptr - r_rd_ptr;
        w_full     = (w_count == FIFO_FULL);
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_push     = cmd_valid && !w_full;
        w_load_err = 1'b0;
        w_load_cmd = 1'b0;
        if (r_state == ST_IDLE) begin
            if (r_err_cnt != 8'h00) begin
                w_load_err = 1'b1;
            end else begin
                w_load_cmd = !w_empty;
            end
        end else begin
            w_load_err = 1'b0;
            w_load_cmd = 1'b0;
        end
        if (w_load_err) begin
            w_frame = build_frame(1'b1, r_err_cnt);
        end else begin
            w_frame = build_frame(1'b0, r_mem[r_rd_ptr[PTR_W-1:0]]);
        end
    end

    assign cmd_ready = !w_full;
    assign up_data   = r_up_data;
    assign up_clk    = r_up_clk;
    assign busy      = r_busy;

    // FIFO data array write (contents are don't-care until pushed)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= cmd_data;
        end
    end

    // FIFO pointers: pop happens only when a command frame is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W1'(1);
            end
            if (w_load_cmd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W1'(1);
            end
        end
    end

    // Saturating error counter; a load hands its value to the frame and
    // keeps an error arriving on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_load_err) begin
            r_err_cnt <= err_in ? 8'h01 : 8'h00;
        end else if (err_in && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    // Transmit FSM and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '1;
            r_bit     <= 4'd0;
            r_cyc     <= '0;
            r_gap     <= '0;
            r_up_data <= 1'b1;
            r_up_clk  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_up_clk <= 1'b0;
                    r_bit    <= 4'd0;
                    r_cyc    <= '0;
                    r_gap    <= '0;
                    if (w_load_err || w_load_cmd) begin
                        r_up_data <= w_frame[0];
                        r_shift   <= w_frame[11:1];
                        r_state   <= ST_SEND;
                        r_busy    <= 1'b1;
                    end else begin
                        r_up_data <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (r_cyc == DIV_LAST) begin
                        r_cyc    <= '0;
                        r_up_clk <= 1'b0;
                        if (r_bit == 4'd11) begin
                            r_state   <= ST_GAP;
                            r_up_data <= 1'b1;
                            r_gap     <= '0;
                        end else begin
                            r_bit     <= r_bit + 4'd1;
                            r_up_data <= r_shift[0];
                            r_shift   <= {1'b1, r_shift[10:1]};
                        end
                    end else begin
                        r_cyc    <= r_cyc + DIV_W'(1);
                        r_up_clk <= (r_cyc == DIV_PRE_MID);
                    end
                end
                ST_GAP: begin
                    r_up_clk  <= 1'b0;
                    r_up_data <= 1'b1;
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_up_data <= 1'b1;
                    r_up_clk  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apix_upstream_tx.sv
// ---------------------------------------------------------------------------
// tb_apix_upstream_tx
//   Directed bench for apix_upstream_tx. Frames are captured from the line on
//   each up_clk strobe and compared with hand-computed 12-bit frame images
//   (bit 0 = start bit). A second instance with a long bit period is used
//   to reach error-counter saturation while a single frame is in flight.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apix_upstream_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       err_in = 1'b0;
    logic       cmd_ready, up_data, up_clk, busy;

    logic [7:0] b_cmd_data = 8'h00;
    logic       b_cmd_valid = 1'b0;
    logic       b_err_in = 1'b0;
    logic       b_cmd_ready, b_up_data, b_up_clk, b_busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic [11:0] frame;
    } vec_t;
    vec_t vecs [0:6];

    always #5 clk = ~clk;

    apix_upstream_tx dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .err_in(err_in), .up_data(up_data),
        .up_clk(up_clk), .busy(busy)
    );

    apix_upstream_tx #(.CLK_DIV(32), .FIFO_DEPTH(2), .GAP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .cmd_data(b_cmd_data), .cmd_valid(b_cmd_valid),
        .cmd_ready(b_cmd_ready), .err_in(b_err_in), .up_data(b_up_data),
        .up_clk(b_up_clk), .busy(b_busy)
    );

    // Frame capture on the strobe for both instances
    logic [11:0] mon_q[$];
    int          mon_start[$];
    logic [11:0] b_q[$];
    int          cyc_cnt = 0;
    int          bitn = 0;
    int          b_bitn = 0;
    logic [11:0] sh;
    logic [11:0] b_sh;

    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (rst) begin
            bitn   = 0;
            b_bitn = 0;
        end else begin
            if (up_clk) begin
                if (bitn == 0) mon_start.push_back(cyc_cnt);
                sh[bitn] = up_data;
                bitn = bitn + 1;
                if (bitn == 12) begin
                    mon_q.push_back(sh);
                    bitn = 0;
                end
            end
            if (b_up_clk) begin
                b_sh[b_bitn] = b_up_data;
                b_bitn = b_bitn + 1;
                if (b_bitn == 12) begin
                    b_q.push_back(b_sh);
                    b_bitn = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_err(input int n);
        for (int k = 0; k < n; k++) begin
            err_in = 1'b1;
            tick();
            err_in = 1'b0;
            tick();
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int k = 0; k < budget && mon_q.size() < n; k++) tick();
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        for (int k = 0; k < budget && busy !== val; k++) tick();
        if (busy !== val) begin
            total++;
            bad++;
            $display("FAIL %s: busy stuck at %0b waiting for %0b", name, busy, val);
        end
    endtask

    task automatic expect_frame(input string name, input logic [11:0] exp);
        logic [11:0] got;
        if (mon_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no frame captured, expected %0h", name, exp);
        end else begin
            got = mon_q.pop_front();
            check(name, {20'h0, got}, {20'h0, exp});
        end
    endtask

    initial begin
        logic [11:0] exp_a5;
        int          errs, pulses, busy_cyc;
        logic [11:0] bgot;

        vecs[0] = '{data: 8'hA5, frame: 12'hA94};
        vecs[1] = '{data: 8'h3C, frame: 12'h8F0};
        vecs[2] = '{data: 8'h00, frame: 12'h800};
        vecs[3] = '{data: 8'hFF, frame: 12'hBFC};
        vecs[4] = '{data: 8'h01, frame: 12'hC04};
        vecs[5] = '{data: 8'h80, frame: 12'hE00};
        vecs[6] = '{data: 8'h7F, frame: 12'hDFC};

        // Reset state
        repeat (3) tick();
        check("rst_up_data", up_data, 1'b1);
        check("rst_up_clk", up_clk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        tick();

        // 0xA5 cycle-exact waveform
        exp_a5 = 12'hA94;
        push(8'hA5);
        check("a5_pre_load_line", up_data, 1'b1);
        check("a5_pre_load_busy", busy, 1'b0);
        errs = 0; pulses = 0; busy_cyc = 0;
        for (int i = 0; i < 56; i++) begin
            tick();
            if (busy === 1'b1) busy_cyc++;
            if (up_clk === 1'b1) pulses++;
            if (i < 48) begin
                if (up_data !== exp_a5[i / 4]) errs++;
                if (up_clk !== ((i % 4) == 2)) errs++;
            end else if (up_data !== 1'b1 || up_clk !== 1'b0) begin
                errs++;
            end
        end
        check("a5_wave_errs", errs, 0);
        check("a5_pulses", pulses, 12);
        tick();
        check("a5_busy_cycles", busy_cyc, 56);
        check("a5_busy_end", busy, 1'b0);
        check("a5_idle_line", up_data, 1'b1);
        expect_frame("a5_frame", 12'hA94);

        // Table of single commands
        for (int v = 0; v < 7; v++) begin
            push(vecs[v].data);
            wait_frames(1, 200);
            expect_frame($sformatf("vec%0d_frame", v), vecs[v].frame);
            wait_busy(1'b0, 200, $sformatf("vec%0d_idle", v));
            tick();
        end

        // Burst of six: fifth fills the FIFO, sixth dropped
        mon_start.delete();
        for (int k = 1; k <= 6; k++) begin
            cmd_data  = 8'(k);
            cmd_valid = 1'b1;
            if (k == 5) check("burst_ready_c5", cmd_ready, 1'b1);
            if (k == 6) check("burst_ready_c6", cmd_ready, 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        wait_frames(5, 400);
        expect_frame("burst_f1", 12'hC04);
        expect_frame("burst_f2", 12'hC08);
        expect_frame("burst_f3", 12'h80C);
        expect_frame("burst_f4", 12'hC10);
        expect_frame("burst_f5", 12'h814);
        if (mon_start.size() >= 5) begin
            for (int k = 1; k < 5; k++)
                check($sformatf("burst_spacing%0d", k), mon_start[k] - mon_start[k-1], 57);
        end else begin
            total++;
            bad++;
            $display("FAIL burst_spacing: only %0d frame starts, expected 5", mon_start.size());
        end
        repeat (100) tick();
        check("burst_no_sixth", mon_q.size(), 0);

        // Error report jumps ahead of a queued command
        push(8'h11);
        push(8'h22);
        tick();
        pulse_err(3);
        wait_frames(3, 250);
        expect_frame("prio_cmd11", 12'h844);
        expect_frame("prio_err3", 12'hC0E);
        expect_frame("prio_cmd22", 12'h888);
        wait_busy(1'b0, 200, "prio_idle");
        tick();

        // Error on the load edge is carried into a second report
        push(8'h11);
        tick();
        pulse_err(2);
        wait_busy(1'b0, 200, "loadedge_idle");
        err_in = 1'b1;
        tick();
        err_in = 1'b0;
        wait_frames(3, 250);
        expect_frame("loadedge_cmd", 12'h844);
        expect_frame("loadedge_err2", 12'h80A);
        expect_frame("loadedge_err1", 12'h806);
        wait_busy(1'b0, 200, "loadedge_end");
        tick();

        // Saturation on the slow instance: 300 errors during one frame
        check("b_ready", b_cmd_ready, 1'b1);
        b_cmd_data  = 8'h5A;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        b_err_in    = 1'b1;
        repeat (300) tick();
        b_err_in = 1'b0;
        check("b_busy_mid", b_busy, 1'b1);
        for (int k = 0; k < 2000 && b_q.size() < 2; k++) tick();
        if (b_q.size() >= 2) begin
            bgot = b_q.pop_front();
            check("sat_cmd5a", {20'h0, bgot}, {20'h0, 12'h968});
            bgot = b_q.pop_front();
            check("sat_errFF", {20'h0, bgot}, {20'h0, 12'hFFE});
        end else begin
            total++;
            bad++;
            $display("FAIL sat_frames: captured %0d frames, expected 2", b_q.size());
        end

        // Reset during bit 5 with two commands queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (20) tick();
        check("rstmid_bit5_line", up_data, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_up_data", up_data, 1'b1);
        check("rstmid_up_clk", up_clk, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        mon_q.delete();
        mon_start.delete();
        busy_cyc = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (busy === 1'b1) busy_cyc++;
        end
        check("rstmid_no_busy", busy_cyc, 0);
        check("rstmid_no_frame", mon_q.size(), 0);
        push(8'h3C);
        wait_frames(1, 200);
        expect_frame("rstmid_3c", 12'h8F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
